// File: rtl/flash_pkg.sv
// Shared types for the NAND flash command front-end.
//   nfc_op_e      operation codes presented to the NFC
//   seq_status_e  per-command response status
//   seq_state_e   sequencer FSM states
//   seq_cmd_t     queued command {op, addr, tag} at the default widths
package flash_pkg;

   localparam int unsigned SeqAddrW = 16;
   localparam int unsigned SeqTagW  = 4;

   typedef enum logic [2:0] {
      OpProgram = 3'b001,
      OpRead    = 3'b010,
      OpReset   = 3'b011,
      OpErase   = 3'b100,
      OpReadId  = 3'b101
   } nfc_op_e;

   typedef enum logic [2:0] {
      SeqOk      = 3'd0,
      SeqPerr    = 3'd1,
      SeqEerr    = 3'd2,
      SeqRerr    = 3'd3,
      SeqTimeout = 3'd4,
      SeqIllegal = 3'd5
   } seq_status_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } seq_state_e;

   // op stays a raw vector so illegal host codes survive the queue.
   typedef struct packed {
      logic [2:0]          op;
      logic [SeqAddrW-1:0] addr;
      logic [SeqTagW-1:0]  tag;
   } seq_cmd_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op >= 3'b001) && (op <= 3'b101);
   endfunction

   // Program error outranks erase error, which outranks read error.
   function automatic seq_status_e err_status(input logic perr, input logic eerr,
                                              input logic rerr);
      if (perr) return SeqPerr;
      if (eerr) return SeqEerr;
      if (rerr) return SeqRerr;
      return SeqOk;
   endfunction

endpackage

// File: rtl/flash_cmd_fifo.sv
// Synchronous command FIFO with asynchronous active-high reset.
//   clk, rst      clock and asynchronous reset (flushes the queue)
//   push, wdata   write request and payload (ignored when full)
//   pop, rdata    read request and head-of-queue payload (ignored when empty)
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
module flash_cmd_fifo
   import flash_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type payload_t = seq_cmd_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  payload_t               wdata,
   input  logic                   pop,
   output payload_t               rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   payload_t    mem [DEPTH];
   // The extra top pointer bit separates a full queue from an empty one.
   logic [AW:0] wptr_q, rptr_q;
   logic        do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr_q[AW-1:0]];
   assign count = wptr_q - rptr_q;
   assign full  = (count == FullCount);
   assign empty = (wptr_q == rptr_q);

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Command front-end for the NAND flash controller: queues host operations and
// issues them one at a time on the nfc_strt/nfc_done handshake, with completion
// timeout, bounded retry on NFC error flags and a tagged response per command.
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/ready/op/addr/tag  host command push interface
//   nfc_cmd, RWA, nfc_strt       operation, row address and start pulse to NFC
//   nfc_done, PErr, EErr, RErr   NFC completion level and error flags
//   rsp_valid/ready/tag/status/retries  response handshake to host
//   busy                         FSM not idle
//   q_count                      FIFO occupancy
module flash_cmd_sequencer
   import flash_pkg::*;
#(
   parameter int unsigned DEPTH          = 8,
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TAG_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRY      = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [TAG_W-1:0]       cmd_tag,
   output logic [2:0]             nfc_cmd,
   output logic [ADDR_W-1:0]      RWA,
   output logic                   nfc_strt,
   input  logic                   nfc_done,
   input  logic                   PErr,
   input  logic                   EErr,
   input  logic                   RErr,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic [2:0]             rsp_status,
   output logic [2:0]             rsp_retries,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] q_count
);

   typedef struct packed {
      logic [2:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
   } cmd_t;

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
   // Leaving WAIT as the counter becomes TIMEOUT_CYCLES-1 puts rsp_valid
   // exactly TIMEOUT_CYCLES cycles after WAIT entry.
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 2);
   localparam logic [2:0]      MaxRetry = 3'(MAX_RETRY);

   seq_state_e        state_q, state_d;
   cmd_t              cur_q, cur_d, head, wr_cmd;
   logic [2:0]        retries_q, retries_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              done_q, done_rise;
   logic              strt_q, strt_d;
   logic [2:0]        nfc_cmd_q, nfc_cmd_d;
   logic [ADDR_W-1:0] rwa_q, rwa_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   seq_status_e       rsp_status_q, rsp_status_d, done_status;
   logic [2:0]        rsp_retries_q, rsp_retries_d;
   logic              fifo_full, fifo_empty, pop;

   assign wr_cmd = '{op: cmd_op, addr: cmd_addr, tag: cmd_tag};

   flash_cmd_fifo #(
      .DEPTH     (DEPTH),
      .payload_t (cmd_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .wdata (wr_cmd),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (q_count)
   );

   // A done level already high when WAIT is entered never forms a rising edge.
   assign done_rise   = nfc_done && !done_q;
   assign done_status = err_status(PErr, EErr, RErr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cur_q         <= '0;
         retries_q     <= '0;
         tmo_q         <= '0;
         done_q        <= 1'b0;
         strt_q        <= 1'b0;
         nfc_cmd_q     <= '0;
         rwa_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_tag_q     <= '0;
         rsp_status_q  <= SeqOk;
         rsp_retries_q <= '0;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         retries_q     <= retries_d;
         tmo_q         <= tmo_d;
         done_q        <= nfc_done;
         strt_q        <= strt_d;
         nfc_cmd_q     <= nfc_cmd_d;
         rwa_q         <= rwa_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_status_q  <= rsp_status_d;
         rsp_retries_q <= rsp_retries_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      retries_d     = retries_q;
      tmo_d         = tmo_q;
      strt_d        = 1'b0;
      nfc_cmd_d     = nfc_cmd_q;
      rwa_d         = rwa_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_status_d  = rsp_status_q;
      rsp_retries_d = rsp_retries_q;
      pop           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop   = 1'b1;
               cur_d = head;
               if (is_legal_op(head.op)) begin
                  state_d = StIssue;
               end else begin
                  state_d       = StResp;
                  rsp_tag_d     = head.tag;
                  rsp_status_d  = SeqIllegal;
                  rsp_retries_d = '0;
               end
            end
         end
         StIssue: begin
            strt_d    = 1'b1;
            nfc_cmd_d = cur_q.op;
            rwa_d     = cur_q.addr;
            tmo_d     = '0;
            state_d   = StWait;
         end
         StWait: begin
            tmo_d = tmo_q + 1'b1;
            if (done_rise) begin
               if (done_status != SeqOk && cur_q.op != OpReset && retries_q < MaxRetry) begin
                  retries_d = retries_q + 1'b1;
                  state_d   = StIssue;
               end else begin
                  state_d       = StResp;
                  rsp_tag_d     = cur_q.tag;
                  rsp_status_d  = done_status;
                  rsp_retries_d = retries_q;
               end
            end else if (tmo_q == TmoLast) begin
               state_d       = StResp;
               rsp_tag_d     = cur_q.tag;
               rsp_status_d  = SeqTimeout;
               rsp_retries_d = retries_q;
            end
         end
         StResp: begin
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               retries_d   = '0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready   = !fifo_full;
   assign nfc_cmd     = nfc_cmd_q;
   assign RWA         = rwa_q;
   assign nfc_strt    = strt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_retries = rsp_retries_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Self-checking bench for flash_cmd_sequencer with a behavioural NFC model and
// a response scoreboard.
module tb_flash_cmd_sequencer;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned TMO    = 100;
   localparam int unsigned MAXR   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [TAG_W-1:0]  cmd_tag = '0;
   logic [2:0]        nfc_cmd;
   logic [ADDR_W-1:0] RWA;
   logic              nfc_strt;
   logic              nfc_done = 1'b0;
   logic              PErr = 1'b0, EErr = 1'b0, RErr = 1'b0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [TAG_W-1:0]  rsp_tag;
   logic [2:0]        rsp_status, rsp_retries;
   logic              busy;
   logic [3:0]        q_count;

   flash_cmd_sequencer #(
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .TAG_W          (TAG_W),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_tag     (cmd_tag),
      .nfc_cmd     (nfc_cmd),
      .RWA         (RWA),
      .nfc_strt    (nfc_strt),
      .nfc_done    (nfc_done),
      .PErr        (PErr),
      .EErr        (EErr),
      .RErr        (RErr),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_tag     (rsp_tag),
      .rsp_status  (rsp_status),
      .rsp_retries (rsp_retries),
      .busy        (busy),
      .q_count     (q_count)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [2:0]       st;
      logic [2:0]       ret;
   } exp_t;

   exp_t              sb[$];
   int                strt_cyc[$];
   int                acc_cyc[$];
   int                total = 0, bad = 0;
   int                cyc = 0, strt_cnt = 0, rsp_cnt = 0;
   logic [ADDR_W-1:0] last_rwa = '0;
   logic [2:0]        last_cmd = '0;
   int                nfc_delay = 3;   // negative: NFC never completes
   bit                perr_m = 0, eerr_m = 0, rerr_m = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // NFC model: done rises nfc_delay cycles after each start pulse.
   initial begin : nfc_model
      bit pending;
      int dcnt;
      pending = 0;
      dcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            nfc_done = 1'b0;
            pending  = 0;
         end else if (nfc_strt) begin
            strt_cnt++;
            strt_cyc.push_back(cyc);
            last_rwa = RWA;
            last_cmd = nfc_cmd;
            nfc_done = 1'b0;
            pending  = 1;
            dcnt     = 0;
         end else if (pending && nfc_delay >= 0) begin
            dcnt++;
            if (dcnt >= nfc_delay) begin
               PErr     = perr_m;
               EErr     = eerr_m;
               RErr     = rerr_m;
               nfc_done = 1'b1;
               pending  = 0;
            end
         end
      end
   end

   // Response monitor: every accepted response is checked against the scoreboard.
   initial begin : rsp_monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            acc_cyc.push_back(cyc);
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected: got tag=%0d status=%0d retries=%0d, required none",
                        rsp_tag, rsp_status, rsp_retries);
            end else begin
               e = sb.pop_front();
               if ({rsp_tag, rsp_status, rsp_retries} !== {e.tag, e.st, e.ret}) begin
                  bad++;
                  $display("FAIL rsp_fields: got tag=%0d status=%0d retries=%0d, required tag=%0d status=%0d retries=%0d",
                           rsp_tag, rsp_status, rsp_retries, e.tag, e.st, e.ret);
               end
            end
         end
      end
   end

   task automatic push(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [TAG_W-1:0] tag);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_tag   = tag;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic expect_rsp(input logic [TAG_W-1:0] tag, input logic [2:0] st,
                             input logic [2:0] ret);
      sb.push_back('{tag: tag, st: st, ret: ret});
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (!(sb.size() == 0 && !busy && q_count == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s_drain: got %0d responses pending after %0d cycles, required 0",
                  name, sb.size(), budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({cmd_ready, busy, nfc_strt, rsp_valid} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_flags: got ready/busy/strt/valid=%b, required 1000",
                  {cmd_ready, busy, nfc_strt, rsp_valid});
      end
      total++;
      if (q_count !== 4'd0) begin
         bad++;
         $display("FAIL reset_q_count: got %0d, required 0", q_count);
      end
      total++;
      if ({nfc_cmd, RWA, rsp_tag, rsp_status, rsp_retries} !== '0) begin
         bad++;
         $display("FAIL reset_fields: got cmd=%0d rwa=%h tag=%0d status=%0d retries=%0d, required all 0",
                  nfc_cmd, RWA, rsp_tag, rsp_status, rsp_retries);
      end
   endtask

   task automatic test_program();
      int s0, n;
      nfc_delay = 40;
      s0 = strt_cnt;
      expect_rsp(4'd3, 3'd0, 3'd0);
      push(3'b001, 16'h1234, 4'd3);
      @(negedge clk);
      total++;
      if ({nfc_strt, busy} !== 2'b01) begin
         bad++;
         $display("FAIL prog_pop_cycle: got strt/busy=%b, required 01", {nfc_strt, busy});
      end
      @(negedge clk);
      total++;
      if ({nfc_strt, nfc_cmd, RWA} !== {1'b1, 3'b001, 16'h1234}) begin
         bad++;
         $display("FAIL prog_issue: got strt=%b cmd=%0d rwa=%h, required strt=1 cmd=1 rwa=1234",
                  nfc_strt, nfc_cmd, RWA);
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!nfc_done && n < 100);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL prog_rsp_early: got rsp_valid=%b one edge after done, required 0", rsp_valid);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL prog_rsp_latency: got rsp_valid=%b two edges after done, required 1", rsp_valid);
      end
      wait_idle(200, "prog");
      total++;
      if (strt_cnt - s0 != 1 || last_rwa !== 16'h1234) begin
         bad++;
         $display("FAIL prog_pulses: got %0d pulses rwa=%h, required 1 pulse rwa=1234",
                  strt_cnt - s0, last_rwa);
      end
   endtask

   task automatic test_fifo_full();
      nfc_delay = -1;
      // The first command moves straight to the NFC; the other eight fill the FIFO.
      for (int i = 0; i < 9; i++) begin
         expect_rsp(4'(i), 3'd0, 3'd0);
         push(3'b010, 16'(16'h0100 + i), 4'(i));
         if (i == 7) begin
            total++;
            if ({cmd_ready, q_count} !== {1'b1, 4'd7}) begin
               bad++;
               $display("FAIL fifo_8th: got ready=%b count=%0d, required ready=1 count=7",
                        cmd_ready, q_count);
            end
         end
      end
      total++;
      if ({cmd_ready, q_count} !== {1'b0, 4'd8}) begin
         bad++;
         $display("FAIL fifo_full: got ready=%b count=%0d, required ready=0 count=8",
                  cmd_ready, q_count);
      end
      push(3'b010, 16'hdead, 4'd15);   // dropped: FIFO full
      total++;
      if (q_count !== 4'd8) begin
         bad++;
         $display("FAIL fifo_drop: got count=%0d after push to full, required 8", q_count);
      end
      nfc_delay = 2;
      wait_idle(2000, "fifo");
   endtask

   task automatic test_retry();
      int s0;
      nfc_delay = 3;
      // Erase with EErr every time: two re-issues then give up.
      eerr_m = 1;
      s0 = strt_cnt;
      expect_rsp(4'd5, 3'd2, 3'd2);
      push(3'b100, 16'h0042, 4'd5);
      wait_idle(500, "retry_erase");
      total++;
      if (strt_cnt - s0 != 3) begin
         bad++;
         $display("FAIL retry_erase_pulses: got %0d, required 3", strt_cnt - s0);
      end
      // Reset op is never retried.
      eerr_m = 0;
      perr_m = 1;
      s0 = strt_cnt;
      expect_rsp(4'd6, 3'd1, 3'd0);
      push(3'b011, 16'h0000, 4'd6);
      wait_idle(500, "retry_reset");
      total++;
      if (strt_cnt - s0 != 1) begin
         bad++;
         $display("FAIL retry_reset_pulses: got %0d, required 1", strt_cnt - s0);
      end
      // All three flags: PErr wins.
      eerr_m = 1;
      rerr_m = 1;
      expect_rsp(4'd7, 3'd1, 3'd2);
      push(3'b001, 16'h0077, 4'd7);
      wait_idle(500, "retry_prio");
      // RErr alone on a read.
      perr_m = 0;
      eerr_m = 0;
      expect_rsp(4'd8, 3'd3, 3'd2);
      push(3'b010, 16'h0088, 4'd8);
      wait_idle(500, "retry_read");
      rerr_m = 0;
   endtask

   task automatic test_timeout();
      int n;
      nfc_delay = -1;
      expect_rsp(4'd9, 3'd4, 3'd0);
      push(3'b101, 16'h0abc, 4'd9);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!nfc_strt && n < 20);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 300);
      total++;
      if (n != TMO) begin
         bad++;
         $display("FAIL timeout_latency: got rsp_valid %0d cycles after WAIT entry, required %0d",
                  n, TMO);
      end
      wait_idle(50, "timeout");
      nfc_delay = 3;
   endtask

   task automatic test_illegal();
      int s0;
      nfc_delay = 3;
      s0 = strt_cnt;
      expect_rsp(4'd10, 3'd5, 3'd0);
      expect_rsp(4'd11, 3'd5, 3'd0);
      expect_rsp(4'd12, 3'd5, 3'd0);
      expect_rsp(4'd4, 3'd0, 3'd0);
      push(3'b111, 16'h1111, 4'd10);
      push(3'b000, 16'h2222, 4'd11);
      push(3'b110, 16'h3333, 4'd12);
      push(3'b010, 16'h0abc, 4'd4);
      wait_idle(300, "illegal");
      total++;
      if (strt_cnt - s0 != 1 || last_rwa !== 16'h0abc || last_cmd !== 3'b010) begin
         bad++;
         $display("FAIL illegal_issue: got %0d pulses rwa=%h cmd=%0d, required 1 pulse rwa=0abc cmd=2",
                  strt_cnt - s0, last_rwa, last_cmd);
      end
   endtask

   task automatic test_back_to_back();
      nfc_delay = 2;
      strt_cyc.delete();
      acc_cyc.delete();
      expect_rsp(4'd1, 3'd0, 3'd0);
      expect_rsp(4'd2, 3'd0, 3'd0);
      push(3'b001, 16'h0010, 4'd1);
      push(3'b010, 16'h0020, 4'd2);
      wait_idle(300, "b2b");
      total++;
      if (strt_cyc.size() != 2 || acc_cyc.size() != 2) begin
         bad++;
         $display("FAIL b2b_counts: got %0d starts %0d responses, required 2 and 2",
                  strt_cyc.size(), acc_cyc.size());
      end else if (strt_cyc[1] - acc_cyc[0] != 3) begin
         bad++;
         $display("FAIL b2b_gap: got start %0d cycles after response, required 3",
                  strt_cyc[1] - acc_cyc[0]);
      end
   endtask

   task automatic test_rst_mid();
      int s1, r0;
      nfc_delay = -1;
      r0 = rsp_cnt;
      for (int i = 0; i < 4; i++) push(3'b100, 16'(16'h0500 + i), 4'(i));
      repeat (5) @(negedge clk);
      total++;
      if ({busy, q_count} !== {1'b1, 4'd3}) begin
         bad++;
         $display("FAIL rstmid_pre: got busy=%b count=%0d, required busy=1 count=3", busy, q_count);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({q_count, busy, cmd_ready, rsp_valid, nfc_strt} !== {4'd0, 4'b0100}) begin
         bad++;
         $display("FAIL rstmid_async: got count=%0d busy=%b ready=%b valid=%b strt=%b, required 0 0 1 0 0",
                  q_count, busy, cmd_ready, rsp_valid, nfc_strt);
      end
      total++;
      if ({nfc_cmd, RWA} !== '0) begin
         bad++;
         $display("FAIL rstmid_nfc: got cmd=%0d rwa=%h, required 0 0", nfc_cmd, RWA);
      end
      @(negedge clk);
      rst = 1'b0;
      s1 = strt_cnt;
      repeat (40) @(negedge clk);
      total++;
      if (strt_cnt != s1 || rsp_cnt != r0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_quiet: got %0d starts %0d responses busy=%b, required 0 0 0",
                  strt_cnt - s1, rsp_cnt - r0, busy);
      end
      nfc_delay = 3;
      expect_rsp(4'd13, 3'd0, 3'd0);
      push(3'b001, 16'h0600, 4'd13);
      wait_idle(200, "rstmid_after");
      total++;
      if (strt_cnt - s1 != 1) begin
         bad++;
         $display("FAIL rstmid_resume: got %0d starts after new push, required 1", strt_cnt - s1);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_fifo_full();
      test_retry();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_rst_mid();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
